// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures mepc/mcause from the older trapping lane, flushes, then redirects.
// Flush/redirect follow the sampling edge by 1..FLUSH_CYCLES+1 cycles; there is no backpressure path.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid0_i,
  input  logic        valid1_i,
  input  logic        trap0_i,
  input  logic        trap1_i,
  input  logic        misaligned_i,
  input  logic [31:0] pc_0_i,
  input  logic [31:0] pc_1_i,
  input  logic        mret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        wb_kill0_o,
  output logic        wb_kill1_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_taken_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o
);

  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  localparam logic [3:0]  CNT_LOAD      = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] CAUSE_MISALGN = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic        taken_q, taken_d;

  logic t0, t1, idle;

  assign t0   = valid0_i & trap0_i;
  assign t1   = valid1_i & trap1_i;
  assign idle = (state_q == ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      rpc_q      <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      mtvec_q    <= MTVEC_RESET & ~32'd3;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      rpc_q      <= rpc_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      mtvec_q    <= mtvec_d;
      taken_q    <= taken_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    rpc_d      = rpc_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    mtvec_d    = mtvec_q;
    taken_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Lane 0 is older, so it wins; a trap or mret swallows any same-cycle CSR write.
        if (t0) begin
          mepc_d   = pc_0_i;
          mcause_d = misaligned_i ? CAUSE_MISALGN : CAUSE_ILLEGAL;
          target_d = mtvec_q;
          taken_d  = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = ST_FLUSH;
        end else if (t1) begin
          mepc_d   = pc_1_i;
          mcause_d = CAUSE_ILLEGAL;
          target_d = mtvec_q;
          taken_d  = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = ST_FLUSH;
        end else if (mret_i && valid0_i) begin
          target_d = mepc_q;
          cnt_d    = CNT_LOAD;
          state_d  = ST_FLUSH;
        end else if (csr_we_i) begin
          case (csr_addr_i)
            ADDR_MTVEC:    mtvec_d    = csr_wdata_i & ~32'd3;
            ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
            ADDR_MEPC:     mepc_d     = csr_wdata_i & ~32'd3;
            ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
            default: ;
          endcase
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          rpc_d   = target_q;
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (csr_addr_i)
      ADDR_MTVEC:    csr_rdata_o = mtvec_q;
      ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
      ADDR_MEPC:     csr_rdata_o = mepc_q;
      ADDR_MCAUSE:   csr_rdata_o = mcause_q;
      default:       csr_rdata_o = 32'd0;
    endcase
  end

  assign wb_kill0_o    = idle & t0;
  assign wb_kill1_o    = idle & (t0 | t1);
  assign flush_o       = ~idle;
  assign redirect_o    = (state_q == ST_REDIRECT);
  assign redirect_pc_o = rpc_q;
  assign trap_taken_o  = taken_q;
  assign mepc_o        = mepc_q;
  assign mcause_o      = mcause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, lane priority, mret, CSR access and reset abort.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid0_i, valid1_i, trap0_i, trap1_i, misaligned_i;
  logic [31:0] pc_0_i, pc_1_i;
  logic        mret_i, csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        wb_kill0_o, wb_kill1_o, flush_o, redirect_o, trap_taken_o;
  logic [31:0] redirect_pc_o, mepc_o, mcause_o;

  int errors = 0;
  int checks = 0;

  trap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid0_i(valid0_i), .valid1_i(valid1_i),
    .trap0_i(trap0_i), .trap1_i(trap1_i), .misaligned_i(misaligned_i),
    .pc_0_i(pc_0_i), .pc_1_i(pc_1_i), .mret_i(mret_i),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .wb_kill0_o(wb_kill0_o), .wb_kill1_o(wb_kill1_o),
    .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .trap_taken_o(trap_taken_o), .mepc_o(mepc_o), .mcause_o(mcause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    valid0_i = 0; valid1_i = 0; trap0_i = 0; trap1_i = 0; misaligned_i = 0;
    pc_0_i = 0; pc_1_i = 0; mret_i = 0; csr_we_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr_i = addr;
    #1;
    check(tag, csr_rdata_o, exp);
  endtask

  // Called in the first cycle after the sampling edge; walks 3 flush cycles, redirect, then idle.
  task automatic expect_seq(input string tag, input logic [31:0] tgt, input logic is_trap);
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_flush"}, 32'(flush_o), 32'd1);
      check({tag, "_redir"}, 32'(redirect_o), (i == 4) ? 32'd1 : 32'd0);
      check({tag, "_taken"}, 32'(trap_taken_o), (is_trap && i == 1) ? 32'd1 : 32'd0);
      if (i == 4) begin
        check({tag, "_rpc"}, redirect_pc_o, tgt);
        clear_inputs();
      end
      tick();
    end
    check({tag, "_flush_end"}, 32'(flush_o), 32'd0);
    check({tag, "_redir_end"}, 32'(redirect_o), 32'd0);
    check({tag, "_rpc_hold"}, redirect_pc_o, tgt);
  endtask

  initial begin
    clear_inputs();
    rst_i = 1;
    tick();
    tick();
    // 1: reset state
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_redir", 32'(redirect_o), 32'd0);
    check("rst_taken", 32'(trap_taken_o), 32'd0);
    check("rst_rpc", redirect_pc_o, 32'd0);
    check("rst_mepc", mepc_o, 32'd0);
    check("rst_mcause", mcause_o, 32'd0);
    rst_i = 0;
    tick();
    rd("rst_mtvec", 12'h305, 32'h100);
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("unmapped_rd", 12'h123, 32'h0);

    // 2: lane 0 misaligned trap
    valid0_i = 1; trap0_i = 1; misaligned_i = 1; pc_0_i = 32'h40;
    #1;
    check("t2_kill0", 32'(wb_kill0_o), 32'd1);
    check("t2_kill1", 32'(wb_kill1_o), 32'd1);
    check("t2_flush_pre", 32'(flush_o), 32'd0);
    tick();
    clear_inputs();
    expect_seq("t2", 32'h100, 1'b1);
    check("t2_mepc", mepc_o, 32'h40);
    check("t2_mcause", mcause_o, 32'd0);

    // 3: both lanes trap; lane 0 wins; later flags during flush are ignored
    valid0_i = 1; trap0_i = 1; pc_0_i = 32'h80;
    valid1_i = 1; trap1_i = 1; pc_1_i = 32'h84;
    #1;
    check("t3_kill0", 32'(wb_kill0_o), 32'd1);
    check("t3_kill1", 32'(wb_kill1_o), 32'd1);
    tick();
    pc_0_i = 32'h300; pc_1_i = 32'h304;
    #1;
    check("t3_kill0_flush", 32'(wb_kill0_o), 32'd0);
    check("t3_kill1_flush", 32'(wb_kill1_o), 32'd0);
    expect_seq("t3", 32'h100, 1'b1);
    check("t3_mepc", mepc_o, 32'h80);
    check("t3_mcause", mcause_o, 32'd2);

    // 4: lane 1 only
    valid0_i = 1; valid1_i = 1; trap1_i = 1; pc_0_i = 32'h1C0; pc_1_i = 32'h1C4;
    #1;
    check("t4_kill0", 32'(wb_kill0_o), 32'd0);
    check("t4_kill1", 32'(wb_kill1_o), 32'd1);
    tick();
    clear_inputs();
    expect_seq("t4", 32'h100, 1'b1);
    check("t4_mepc", mepc_o, 32'h1C4);
    rd("t4_mcause_rd", 12'h342, 32'd2);

    // 5: CSR writes, then mret (with a discarded same-cycle write)
    csr_we_i = 1; csr_addr_i = 12'h341; csr_wdata_i = 32'h203;
    tick();
    csr_addr_i = 12'h340; csr_wdata_i = 32'hDEADBEEF;
    tick();
    csr_addr_i = 12'h123; csr_wdata_i = 32'h55;
    tick();
    clear_inputs();
    rd("t5_mepc_rd", 12'h341, 32'h200);
    rd("t5_mscratch_rd", 12'h340, 32'hDEADBEEF);
    rd("t5_unmapped_rd", 12'h123, 32'h0);
    valid0_i = 1; mret_i = 1; csr_we_i = 1; csr_addr_i = 12'h340; csr_wdata_i = 32'h11;
    tick();
    clear_inputs();
    expect_seq("t5", 32'h200, 1'b0);
    rd("t5_mscratch_kept", 12'h340, 32'hDEADBEEF);
    check("t5_mepc_kept", mepc_o, 32'h200);
    check("t5_mcause_kept", mcause_o, 32'd2);

    // mtvec write masking, then trap with same-cycle mret and mtvec write
    csr_we_i = 1; csr_addr_i = 12'h305; csr_wdata_i = 32'h307;
    tick();
    clear_inputs();
    rd("mtvec_mask", 12'h305, 32'h304);
    valid0_i = 1; trap0_i = 1; pc_0_i = 32'h10; mret_i = 1;
    csr_we_i = 1; csr_addr_i = 12'h305; csr_wdata_i = 32'h600;
    tick();
    clear_inputs();
    expect_seq("tw", 32'h304, 1'b1);
    rd("tw_mtvec_kept", 12'h305, 32'h304);
    check("tw_mepc", mepc_o, 32'h10);
    check("tw_mcause", mcause_o, 32'd2);

    // 6: reset in the 2nd flush cycle aborts the sequence
    valid0_i = 1; trap0_i = 1; pc_0_i = 32'h50;
    tick();
    clear_inputs();
    tick();
    check("t6_flush_pre", 32'(flush_o), 32'd1);
    rst_i = 1;
    #1;
    check("t6_flush", 32'(flush_o), 32'd0);
    check("t6_redir", 32'(redirect_o), 32'd0);
    check("t6_taken", 32'(trap_taken_o), 32'd0);
    check("t6_rpc", redirect_pc_o, 32'd0);
    check("t6_mepc", mepc_o, 32'd0);
    check("t6_mcause", mcause_o, 32'd0);
    rd("t6_mtvec", 12'h305, 32'h100);
    tick();
    rst_i = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_no_redir", 32'(redirect_o), 32'd0);
      check("t6_no_flush", 32'(flush_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer that sits directly downstream of the dual-lane writeback stage. It consumes the per-lane trap flags, PCs and valids at writeback and prioritises lane 0 as the older instruction. It captures mepc/mcause, flushes the pipeline for a fixed drain period, then redirects fetch to mtvec. It also sequences mret back to mepc and holds the four M-mode trap CSRs.

Parameters:
MTVEC_RESET, 32'h0000_0100, reset value of mtvec (bits [1:0] forced 0)
FLUSH_CYCLES, 3, cycles flush_o is held before redirect; legal range 1..15

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
valid0_i  in  1  lane 0 instruction valid at writeback
valid1_i  in  1  lane 1 instruction valid at writeback
trap0_i  in  1  lane 0 trap flag from writeback
trap1_i  in  1  lane 1 trap flag from writeback
misaligned_i  in  1  lane 0 trap cause is misaligned branch target (else illegal)
pc_0_i  in  32  lane 0 PC
pc_1_i  in  32  lane 1 PC
mret_i  in  1  lane 0 is a valid mret
csr_we_i  in  1  CSR write strobe
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  CSR write data
csr_rdata_o  out  32  CSR read data (combinational)
wb_kill0_o  out  1  suppress lane 0 register write
wb_kill1_o  out  1  suppress lane 1 register write
flush_o  out  1  squash all in-flight instructions
redirect_o  out  1  one-cycle fetch redirect strobe
redirect_pc_o  out  32  redirect target
trap_taken_o  out  1  one-cycle pulse on trap entry
mepc_o  out  32  current mepc
mcause_o  out  32  current mcause

Behaviour:
- Reset: state IDLE; counter 0; flush_o, redirect_o, trap_taken_o = 0; redirect_pc_o = 0; mepc = 0; mcause = 0; mscratch = 0; mtvec = MTVEC_RESET & ~3. Reset asserted mid-FLUSH or mid-REDIRECT returns to IDLE and no redirect is issued.
- Effective trap flags: t0 = valid0_i & trap0_i; t1 = valid1_i & trap1_i.
- Kill outputs are combinational and are forced 0 outside IDLE:
  - wb_kill0_o = t0
  - wb_kill1_o = t0 | t1
- IDLE priority, evaluated at each clock edge:
  1. t0: mepc <= pc_0_i; mcause <= misaligned_i ? 0 : 2; go to FLUSH with target mtvec.
  2. Else t1: mepc <= pc_1_i; mcause <= 2; lane 0 retires normally; go to FLUSH with target mtvec.
  3. Else mret_i & valid0_i: go to FLUSH with target mepc; mepc and mcause are unchanged.
  4. Else csr_we_i: perform the CSR write.
  - A trap in the same cycle as a CSR write discards the write; mret in the same cycle as a trap is ignored.
- FLUSH:
  - flush_o = 1; the counter loads FLUSH_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to REDIRECT.
  - Traps, mret and CSR writes are ignored.
  - trap_taken_o = 1 only on the first FLUSH cycle of a trap entry; it stays 0 for mret.
- REDIRECT: redirect_o = 1, flush_o = 1, redirect_pc_o = latched target; next state IDLE.
- Timing: for an event sampled at edge N, flush_o is high in cycles N+1 through N+FLUSH_CYCLES+1, and redirect_o is high in cycle N+FLUSH_CYCLES+1.
- redirect_pc_o holds its last value when redirect_o = 0.
- CSR map: mscratch 0x340, mtvec 0x305, mepc 0x341, mcause 0x342.
  - Writes to mtvec and mepc force bits [1:0] = 0.
  - Writes to unmapped addresses are ignored; reads of unmapped addresses return 0.
  - Reads are combinational from current register values.
- The target latched for mtvec is the value before any same-cycle write; no write can occur in the trap cycle in any case.

Test Plan:
1. Reset, then read 0x305 -> csr_rdata_o = 32'h100; all strobes 0.
2. t0 with pc_0_i = 32'h40, misaligned_i = 1 -> wb_kill0/1 = 1 that cycle; flush_o high 4 cycles; redirect_o in the 4th with redirect_pc_o = 32'h100; mepc = 32'h40, mcause = 0; trap_taken_o pulses once.
3. t0 (pc 32'h80) and t1 (pc 32'h84) in the same cycle -> mepc = 32'h80, mcause = 2; second trap flags during FLUSH ignored.
4. Only t1, pc_1_i = 32'h1C4 -> wb_kill0_o = 0, wb_kill1_o = 1; mepc = 32'h1C4, mcause = 2.
5. Write mepc = 32'h203 -> reads 32'h200; mret -> redirect_pc_o = 32'h200; trap_taken_o stays 0.
6. Trap, then rst_i asserted in the 2nd FLUSH cycle -> all outputs 0 immediately; no redirect after release.
